// File: rtl/morse_keyer.sv
// Morse transmit keyer: turns a letter index (0=A..25=Z) into a timed key waveform.
// Dots last one unit, dashes three units. Gaps are one unit between symbols and three units after the letter.
module morse_keyer #(
    parameter int unsigned UNIT_CYCLES = 12_000_000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] letter_num,
    output logic       key_out,
    output logic [1:0] sym,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [CNT_W-1:0] LIM_1U      = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM_3U      = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [4:0]       LAST_LETTER = 5'd25;
    localparam logic [1:0]       SYM_NONE    = 2'b00;
    localparam logic [1:0]       SYM_DOT     = 2'b01;
    localparam logic [1:0]       SYM_DASH    = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_LGAP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_pat;    // remaining symbols, current one in bit 3 (1 = dash)
    logic [2:0]       r_rem;    // symbols left including the current one

    // ROM entry: {length[2:0], pattern[3:0]} with the pattern left-aligned
    function automatic logic [6:0] rom_lookup(input logic [4:0] l);
        logic [6:0] v;
        case (l)
            5'd0:  v = {3'd2, 4'b0100};
            5'd1:  v = {3'd4, 4'b1000};
            5'd2:  v = {3'd4, 4'b1010};
            5'd3:  v = {3'd3, 4'b1000};
            5'd4:  v = {3'd1, 4'b0000};
            5'd5:  v = {3'd4, 4'b0010};
            5'd6:  v = {3'd3, 4'b1100};
            5'd7:  v = {3'd4, 4'b0000};
            5'd8:  v = {3'd2, 4'b0000};
            5'd9:  v = {3'd4, 4'b0111};
            5'd10: v = {3'd3, 4'b1010};
            5'd11: v = {3'd4, 4'b0100};
            5'd12: v = {3'd2, 4'b1100};
            5'd13: v = {3'd2, 4'b1000};
            5'd14: v = {3'd3, 4'b1110};
            5'd15: v = {3'd4, 4'b0110};
            5'd16: v = {3'd4, 4'b1101};
            5'd17: v = {3'd3, 4'b0100};
            5'd18: v = {3'd3, 4'b0000};
            5'd19: v = {3'd1, 4'b1000};
            5'd20: v = {3'd3, 4'b0010};
            5'd21: v = {3'd4, 4'b0001};
            5'd22: v = {3'd3, 4'b0110};
            5'd23: v = {3'd4, 4'b1001};
            5'd24: v = {3'd4, 4'b1011};
            5'd25: v = {3'd4, 4'b1100};
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    logic [6:0]       w_rom;
    logic [CNT_W-1:0] w_mark_lim;

    assign w_rom      = rom_lookup(letter_num);
    assign w_mark_lim = r_pat[3] ? LIM_3U : LIM_1U;

    // Sequencer with registered outputs, each loaded alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pat   <= '0;
            r_rem   <= '0;
            key_out <= 1'b0;
            sym     <= SYM_NONE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (letter_num > LAST_LETTER) begin
                            err <= 1'b1;
                        end else begin
                            r_state <= S_MARK;
                            r_cnt   <= '0;
                            r_pat   <= w_rom[3:0];
                            r_rem   <= w_rom[6:4];
                            busy    <= 1'b1;
                            key_out <= 1'b1;
                            sym     <= w_rom[3] ? SYM_DASH : SYM_DOT;
                        end
                    end
                end
                S_MARK: begin
                    if (r_cnt == w_mark_lim) begin
                        r_cnt   <= '0;
                        key_out <= 1'b0;
                        sym     <= SYM_NONE;
                        if (r_rem > 3'd1) begin
                            r_state <= S_SPACE;
                            r_rem   <= r_rem - 3'd1;
                            r_pat   <= {r_pat[2:0], 1'b0};
                        end else begin
                            r_state <= S_LGAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SPACE: begin
                    if (r_cnt == LIM_1U) begin
                        r_cnt   <= '0;
                        r_state <= S_MARK;
                        key_out <= 1'b1;
                        sym     <= r_pat[3] ? SYM_DASH : SYM_DOT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LGAP: begin
                    if (r_cnt == LIM_3U) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
